// File: rtl/sequence_detector.sv
// Serial pattern detector: flags every (overlapping) occurrence of PATTERN in the bit stream.
// Optional saturating match counter enabled by defining SEQ_DET_COUNT_EN.
module sequence_detector #(
  parameter int unsigned       WIDTH   = 4,
  parameter logic [WIDTH-1:0]  PATTERN = WIDTH'(4'b1011),
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seq,
  output logic             detected
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("sequence_detector: WIDTH must be in 2..16");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("sequence_detector: CNT_W must be at least 1");
  end

  localparam int unsigned       FILL_W   = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
  // One bit short of full: the incoming bit completes the first full window.
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(WIDTH - 1);

  logic [WIDTH-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              det_q,  det_d;

  // NOTE: every variable written here gets a value before any condition, so no latch is inferred.
  always_comb begin
    hist_d = {hist_q[WIDTH-2:0], seq};
    fill_d = fill_q;
    if (fill_q != FILL_MAX) begin
      fill_d = fill_q + FILL_W'(1);
    end
    det_d  = (hist_d == PATTERN) && (fill_q >= FILL_ARM);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
    end
  end

  assign detected = det_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts on the same edge that loads a match into the flag, holding at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (det_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_sequence_detector.sv
// Self-checking bench for sequence_detector: four configurations share one stream and reset,
// checked every cycle against a bit-history reference model plus directed literal expectations.
module tb_sequence_detector;

  logic clk;
  logic rst_n;
  logic seq;

  logic det_a, det_z, det_r, det_w;
`ifdef SEQ_DET_COUNT_EN
  logic [7:0] cnt_a;
  logic [1:0] cnt_z;
  logic [3:0] cnt_r;
  logic [2:0] cnt_w;
`endif

  sequence_detector u_a (
    .clk(clk), .rst_n(rst_n), .seq(seq), .detected(det_a)
`ifdef SEQ_DET_COUNT_EN
    , .match_count(cnt_a)
`endif
  );

  sequence_detector #(.WIDTH(4), .PATTERN(4'b0000), .CNT_W(2)) u_z (
    .clk(clk), .rst_n(rst_n), .seq(seq), .detected(det_z)
`ifdef SEQ_DET_COUNT_EN
    , .match_count(cnt_z)
`endif
  );

  sequence_detector #(.WIDTH(7), .PATTERN(7'b1100101), .CNT_W(4)) u_r (
    .clk(clk), .rst_n(rst_n), .seq(seq), .detected(det_r)
`ifdef SEQ_DET_COUNT_EN
    , .match_count(cnt_r)
`endif
  );

  sequence_detector #(.WIDTH(2), .PATTERN(2'b01), .CNT_W(3)) u_w (
    .clk(clk), .rst_n(rst_n), .seq(seq), .detected(det_w)
`ifdef SEQ_DET_COUNT_EN
    , .match_count(cnt_w)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every bit since reset, newest at the back.
  bit hist[$];
  int nbits = 0;
  bit exp_a = 0, exp_z = 0, exp_r = 0, exp_w = 0;
  int ecnt_a = 0, ecnt_z = 0, ecnt_r = 0, ecnt_w = 0;

  function automatic bit model_match(input int w, input logic [15:0] p);
    if (nbits < w) return 1'b0;
    for (int i = 0; i < w; i++) begin
      if (hist[hist.size() - 1 - i] != p[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int sat_inc(input int v, input bit hit, input int cw);
    int top = (1 << cw) - 1;
    if (hit && v < top) return v + 1;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      nbits  = 0;
      exp_a  = 0; exp_z = 0; exp_r = 0; exp_w = 0;
      ecnt_a = 0; ecnt_z = 0; ecnt_r = 0; ecnt_w = 0;
    end else begin
      hist.push_back(seq);
      if (hist.size() > 16) void'(hist.pop_front());
      if (nbits < 1000) nbits++;
      exp_a  = model_match(4, 16'b1011);
      exp_z  = model_match(4, 16'b0000);
      exp_r  = model_match(7, 16'b1100101);
      exp_w  = model_match(2, 16'b01);
      ecnt_a = sat_inc(ecnt_a, exp_a, 8);
      ecnt_z = sat_inc(ecnt_z, exp_z, 2);
      ecnt_r = sat_inc(ecnt_r, exp_r, 4);
      ecnt_w = sat_inc(ecnt_w, exp_w, 3);
    end
  end

  always @(negedge clk) begin
    check("model_det_a", 32'(det_a), 32'(exp_a));
    check("model_det_z", 32'(det_z), 32'(exp_z));
    check("model_det_r", 32'(det_r), 32'(exp_r));
    check("model_det_w", 32'(det_w), 32'(exp_w));
`ifdef SEQ_DET_COUNT_EN
    check("model_cnt_a", 32'(cnt_a), 32'(ecnt_a));
    check("model_cnt_z", 32'(cnt_z), 32'(ecnt_z));
    check("model_cnt_r", 32'(cnt_r), 32'(ecnt_r));
    check("model_cnt_w", 32'(cnt_w), 32'(ecnt_w));
`endif
  end

  // Bit changes on the falling edge; returns 1 time unit after the sampling edge.
  task automatic drive(input logic b);
    @(negedge clk);
    seq = b;
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the whole pulse lies between edges.
  task automatic pulse_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    check({tag, "_async_clr_a"}, 32'(det_a), 32'd0);
    check({tag, "_async_clr_z"}, 32'(det_z), 32'd0);
`ifdef SEQ_DET_COUNT_EN
    check({tag, "_async_cnt_a"}, 32'(cnt_a), 32'd0);
`endif
    #1 rst_n = 1'b1;
  endtask

  logic [0:8] plan_bits = 9'b010101110;
  logic [0:8] plan_exp  = 9'b000000100;
  logic [0:6] ovl_bits  = 7'b1011011;
  logic [0:6] ovl_exp   = 7'b0001001;
  logic [0:8] nom_bits  = 9'b001110010;
  logic [0:7] fill_exp  = 8'b00011111;

  initial begin
    rst_n = 1'b0;
    seq   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_det_a", 32'(det_a), 32'd0);
    check("reset_det_r", 32'(det_r), 32'd0);
`ifdef SEQ_DET_COUNT_EN
    check("reset_cnt_a", 32'(cnt_a), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(plan_bits[i]);
      check($sformatf("plan_det_%0d", i), 32'(det_a), 32'(plan_exp[i]));
    end
`ifdef SEQ_DET_COUNT_EN
    check("plan_cnt", 32'(cnt_a), 32'd1);
`endif
    pulse_reset("after_plan");

    for (int i = 0; i < 7; i++) begin
      drive(ovl_bits[i]);
      check($sformatf("overlap_det_%0d", i), 32'(det_a), 32'(ovl_exp[i]));
    end
`ifdef SEQ_DET_COUNT_EN
    check("overlap_cnt", 32'(cnt_a), 32'd2);
`endif
    // Flag is high here, so the pulse proves the clear is asynchronous.
    pulse_reset("overlap_hi");

    for (int i = 0; i < 9; i++) begin
      drive(nom_bits[i]);
      check($sformatf("nomatch_det_%0d", i), 32'(det_a), 32'd0);
    end
    pulse_reset("after_nomatch");

    drive(1'b1);
    drive(1'b0);
    drive(1'b1);
    pulse_reset("mid_pattern");
    drive(1'b1);
    check("mid_pattern_discard", 32'(det_a), 32'd0);
    pulse_reset("before_fill");

    for (int i = 0; i < 8; i++) begin
      drive(1'b0);
      check($sformatf("fill_guard_%0d", i), 32'(det_z), 32'(fill_exp[i]));
    end
`ifdef SEQ_DET_COUNT_EN
    check("sat_cnt_z", 32'(cnt_z), 32'd3);
`endif
    check("sat_det_still", 32'(det_z), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(1, 0)));
      if ($urandom_range(249, 0) == 0) pulse_reset("random");
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_detector.md
# sequence_detector

Serial bit-stream pattern detector. It samples one input bit per clock and raises a registered one-cycle flag whenever the most recent `WIDTH` bits equal a programmable pattern. Overlapping occurrences are detected. It sits at the front of a serial receive path as a sync/marker detector feeding downstream control logic.

## Interface
- `WIDTH`, default 4: pattern length in bits, legal range 2..16.
- `PATTERN`, default 4'b1011: target sequence. The MSB is the oldest bit received; the LSB is the newest.
- `CNT_W`, default 8: width of the match counter. Used only when `SEQ_DET_COUNT_EN` is defined.

Ports:
- `clk`  input  1: sole clock. All sampling is on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `seq`  input  1: serial data bit, sampled every rising edge.
- `detected`  output  1: registered match flag, high for one cycle per match.
- `match_count`  output  `CNT_W`: saturating count of matches. This port exists only with `SEQ_DET_COUNT_EN`.

## Operation
- History register `hist[WIDTH-1:0]` and fill counter `fill` (0..`WIDTH`, saturating). The fill counter suppresses false matches before `WIDTH` bits have arrived since reset.
- At each rising edge:
  - `hist <= {hist[WIDTH-2:0], seq}`.
  - `fill <= min(fill+1, WIDTH)`.
  - `detected <= ({hist[WIDTH-2:0], seq} == PATTERN) && (fill >= WIDTH-1)`.
- Overlap is allowed: history is never cleared on a match.
  - With `PATTERN`=1011, the stream 1011011 yields two matches.
  - With `PATTERN`=1111, the stream 11111 yields two consecutive `detected` cycles.
- No enable input. Every rising edge consumes one bit.
- Equivalent FSM view for the default pattern, states named by longest matched prefix:
  - S0 (none): 1 -> S1, 0 -> S0.
  - S1 ("1"): 0 -> S10, 1 -> S1.
  - S10 ("10"): 1 -> S101, 0 -> S0.
  - S101 ("101"): 1 -> match, go to S1; 0 -> S10.
  - A shift-register or FSM implementation is acceptable if it is cycle-identical to the equations above for every `PATTERN`.
- Reset (`rst_n`=0, any time, asynchronous):
  - `hist`=0, `fill`=0, `detected`=0, `match_count`=0.
  - A partial match in progress is discarded.
  - After release, a full `WIDTH` fresh bits are required before any match.

## Timing
- Latency: `detected` rises at the same rising edge that samples the final pattern bit and stays high for exactly one clock period.
- `detected` is a pure flop output with no combinational path from `seq`.
- Earliest possible assertion after reset release: the `WIDTH`-th sampled edge.
- Reset assertion clears outputs immediately, without waiting for a clock edge. Release is synchronous in effect: the first sample occurs on the first rising edge with `rst_n`=1.
- `seq` must meet setup/hold around the `clk` rising edge. It is normally driven on the falling edge.

## Configuration
- Macro: `SEQ_DET_COUNT_EN`.
- Defined:
  - Adds the `match_count` port.
  - The counter increments on every edge where `detected` is loaded with 1, so it updates in the same cycle `detected` rises.
  - It saturates at 2^`CNT_W`-1 and is cleared by `rst_n`.
- Undefined: no counter logic and no `match_count` port. `detected` behaviour is identical in both builds.

## Test plan
- Defaults; reset low, then high. Clock period 10, rising edges at t=5,15,25,…; `seq` changes at t=10,20,….
  - Stimulus: `seq` bits sampled at successive edges are 0,1,0,1,0,1,1,1,0.
  - Required: `detected`=1 only from the edge at t=65 to t=75 (bits 1,0,1,1 sampled at t=35..65); 0 at all other times; `match_count`=1 at end.
- Overlap: 1,0,1,1,0,1,1 -> `detected` pulses after the 4th and 7th bits; `match_count`=2.
- Early-fill guard: `PATTERN`=4'b0000; hold `seq`=0 from reset release -> first pulse only after the 4th edge, then high on every subsequent edge.
- Reset mid-pattern: send 1,0,1, pulse `rst_n` low asynchronously between edges, then send 1 -> no pulse. `detected`=0 immediately when `rst_n` falls, not waiting for an edge.
- Saturation (`SEQ_DET_COUNT_EN`, `CNT_W`=2): five matches -> `match_count` stops at 3; `detected` still pulses for every match.
- Non-match stream: 0,0,1,1,1,0,0,1,0 -> `detected` never asserts.
